step_tracker: RTL and testbench
===============================

Name: step_tracker

Overview:
Observer/decoder for the 2-bit up/down modulo-4 state sequence produced by the team's simple up/down counter FSMs. It samples the 2-bit state stream, infers each step's direction and accumulates a signed-by-wrap position count. It also detects illegal jumps (a change of 2) and enters a sticky fault state after repeated errors. It sits on the consumer side of any block exporting such a 2-bit state.

Parameters:
POS_WIDTH, 8, width of the position accumulator (wraps modulo 2^POS_WIDTH)
ERR_LIMIT, 3, number of consecutive illegal samples that forces FAULT (legal range 1..15)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; all state cleared on the clock edge where reset=0
sample_valid  input  1  state_in is sampled on this edge when 1
state_in  input  2  observed 2-bit counter state
clear_fault  input  1  returns FAULT to UNLOCKED; ignored in other states
position  output  POS_WIDTH  accumulated step count
dir_up  output  1  direction of the most recent legal non-zero step (1=up, 0=down)
step_pulse  output  1  one-cycle pulse: a legal step was counted
err_pulse  output  1  one-cycle pulse: an illegal jump was detected
locked  output  1  1 while in TRACKING
fault  output  1  1 while in FAULT
tracker_state  output  2  FSM state encoding: 0=UNLOCKED, 1=TRACKING, 2=FAULT

Behaviour:
- Reset (reset=0 at the clock edge), including mid-operation: the FSM goes to UNLOCKED. position=0, dir_up=1, step_pulse=0, err_pulse=0, locked=0, fault=0, and the internal last-sample and consecutive-error counters are cleared. Reset has priority over every other input.
- All outputs are registered. A response appears one cycle after the sampling edge.
- step_pulse and err_pulse are 0 on any cycle that has no qualifying sample.
- delta = (state_in - last) mod 4, using 2-bit wrap arithmetic. It is evaluated only when sample_valid=1.
- UNLOCKED:
  - sample_valid=1: store last=state_in, go to TRACKING. No step is counted and position is unchanged.
  - sample_valid=0: stay in UNLOCKED.
- TRACKING, on sample_valid=1 (last is always updated to state_in):
  - delta=0: hold. No pulse. The error counter is cleared.
  - delta=1: position+1 (wraps 2^POS_WIDTH-1 -> 0), dir_up=1, step_pulse=1. The error counter is cleared.
  - delta=3: position-1 (wraps 0 -> 2^POS_WIDTH-1), dir_up=0, step_pulse=1. The error counter is cleared.
  - delta=2: position and dir_up are unchanged, err_pulse=1, and the error counter is incremented. If the incremented count equals ERR_LIMIT, go to FAULT in the same cycle.
- FAULT:
  - Samples are ignored. position and dir_up are frozen and no pulses are produced.
  - clear_fault=1: go to UNLOCKED and clear the error counter. position is retained.
  - clear_fault is ignored in UNLOCKED and TRACKING.
- Simultaneous events: in FAULT, clear_fault=1 together with sample_valid=1 gives UNLOCKED, and that sample is not used for locking.
- The error counter saturates at ERR_LIMIT. Its width is 4 bits.
- Unused tracker_state encoding 3 recovers to UNLOCKED on the next edge.

Test Plan:
- Reset, then samples 0,1,2,3,0 -> locked=1 after the first sample. step_pulse on 4 cycles, position=4, dir_up=1.
- From a fresh lock at 0, samples 3,2 -> position wraps to 0xFF then 0xFE, dir_up=0, step_pulse on each.
- Locked at 1, samples 3,1,3 (three delta=2 jumps) with ERR_LIMIT=3 -> err_pulse on each, fault=1 after the third, position unchanged. Further samples have no effect. clear_fault -> tracker_state=0, then the next sample relocks.
- Locked at 0, samples 2,2,3 -> one err_pulse, then a hold, then an up step. The error counter is cleared and no fault occurs. A repeated identical sample produces no pulse.
- Position near the top: drive position to 0xFE, then 2 up steps -> 0xFF then 0x00.
- Reset=0 asserted mid-sequence with position=5 in TRACKING -> next cycle position=0, locked=0, dir_up=1. sample_valid gaps (0) between samples do not change any output.

Source files
------------

// File: rtl/step_tracker_if.sv
// Bundle between a 2-bit counter-state producer side and the step tracker.
// The master drives samples and fault clears; the slave reports tracking status.
interface step_tracker_if #(
    parameter int POS_WIDTH = 8
);
    logic                 sample_valid;
    logic [1:0]           state_in;
    logic                 clear_fault;
    logic [POS_WIDTH-1:0] position;
    logic                 dir_up;
    logic                 step_pulse;
    logic                 err_pulse;
    logic                 locked;
    logic                 fault;
    logic [1:0]           tracker_state;

    modport master (
        output sample_valid, state_in, clear_fault,
        input  position, dir_up, step_pulse, err_pulse,
        input  locked, fault, tracker_state
    );

    modport slave (
        input  sample_valid, state_in, clear_fault,
        output position, dir_up, step_pulse, err_pulse,
        output locked, fault, tracker_state
    );
endinterface

// File: rtl/step_tracker.sv
// Decodes a modulo-4 up/down state stream into a wrapping position count,
// flagging illegal jumps and latching a fault after repeated errors.
module step_tracker #(
    parameter int POS_WIDTH = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic           clock,
    input  logic           reset,
    step_tracker_if.slave  bus
);
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACKING = 2'd1,
        FAULT    = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    localparam logic [3:0]           P_LIM = 4'(ERR_LIMIT);
    localparam logic [POS_WIDTH-1:0] P_ONE = POS_WIDTH'(1);

    state_t               r_state;
    logic [1:0]           r_last;
    logic [3:0]           r_err_cnt;
    logic [POS_WIDTH-1:0] r_pos;
    logic                 r_dir;
    logic                 r_step;
    logic                 r_err;

    logic [1:0]           w_delta;
    logic [3:0]           w_err_inc;

    // Step size from the previous sample, with 2-bit wrap.
    always_comb begin
        w_delta   = bus.state_in - r_last;
        w_err_inc = (r_err_cnt >= P_LIM) ? P_LIM : r_err_cnt + 4'd1;
    end

    // Tracker FSM with all status outputs held in registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= UNLOCKED;
            r_last    <= 2'd0;
            r_err_cnt <= 4'd0;
            r_pos     <= '0;
            r_dir     <= 1'b1;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                UNLOCKED: begin
                    if (bus.sample_valid) begin
                        r_last  <= bus.state_in;
                        r_state <= TRACKING;
                    end
                end
                TRACKING: begin
                    if (bus.sample_valid) begin
                        r_last <= bus.state_in;
                        unique case (w_delta)
                            2'd0: r_err_cnt <= 4'd0;
                            2'd1: begin
                                r_pos     <= r_pos + P_ONE;
                                r_dir     <= 1'b1;
                                r_step    <= 1'b1;
                                r_err_cnt <= 4'd0;
                            end
                            2'd3: begin
                                r_pos     <= r_pos - P_ONE;
                                r_dir     <= 1'b0;
                                r_step    <= 1'b1;
                                r_err_cnt <= 4'd0;
                            end
                            2'd2: begin
                                r_err     <= 1'b1;
                                r_err_cnt <= w_err_inc;
                                if (w_err_inc == P_LIM)
                                    r_state <= FAULT;
                            end
                        endcase
                    end
                end
                FAULT: begin
                    if (bus.clear_fault) begin
                        r_err_cnt <= 4'd0;
                        r_state   <= UNLOCKED;
                    end
                end
                UNUSED: r_state <= UNLOCKED;
            endcase
        end
    end

    assign bus.position      = r_pos;
    assign bus.dir_up        = r_dir;
    assign bus.step_pulse    = r_step;
    assign bus.err_pulse     = r_err;
    assign bus.locked        = (r_state == TRACKING);
    assign bus.fault         = (r_state == FAULT);
    assign bus.tracker_state = r_state;
endmodule

// File: tb/tb_step_tracker.sv
// Directed bench for step_tracker: stimulus pushes hand-computed responses,
// a monitor pops and compares them one cycle after each sampling edge.
module tb_step_tracker;
    logic clock;
    logic reset;

    step_tracker_if #(.POS_WIDTH(8)) bus ();

    step_tracker #(.POS_WIDTH(8), .ERR_LIMIT(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] pos;
        logic       dir;
        logic       step;
        logic       err;
        logic       lck;
        logic       flt;
        logic [1:0] st;
    } resp_t;

    resp_t       exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        done     = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one vector for the next rising edge and queue its expected response.
    task automatic drv(input string nm,
                       input logic rst_n, input logic sv,
                       input logic [1:0] si, input logic cf,
                       input logic [7:0] pos, input logic dir,
                       input logic stp, input logic er,
                       input logic [1:0] st);
        resp_t e;
        @(negedge clock);
        reset            = rst_n;
        bus.sample_valid = sv;
        bus.state_in     = si;
        bus.clear_fault  = cf;
        e.pos  = pos;
        e.dir  = dir;
        e.step = stp;
        e.err  = er;
        e.lck  = (st == 2'd1);
        e.flt  = (st == 2'd2);
        e.st   = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the registered outputs just after each edge.
    initial begin
        resp_t a;
        resp_t e;
        string nm;
        while (!done) begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.pos  = bus.position;
                a.dir  = bus.dir_up;
                a.step = bus.step_pulse;
                a.err  = bus.err_pulse;
                a.lck  = bus.locked;
                a.flt  = bus.fault;
                a.st   = bus.tracker_state;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got pos=%h dir=%b step=%b err=%b lck=%b flt=%b st=%0d want pos=%h dir=%b step=%b err=%b lck=%b flt=%b st=%0d",
                             nm, a.pos, a.dir, a.step, a.err, a.lck, a.flt, a.st,
                             e.pos, e.dir, e.step, e.err, e.lck, e.flt, e.st);
                end
            end
        end
    end

    initial begin
        reset            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.state_in     = 2'd0;
        bus.clear_fault  = 1'b0;

        // Up sequence 0,1,2,3,0 with a gap
        drv("rst",      0,0,0,0, 8'h00,1,0,0,0);
        drv("up_lock",  1,1,0,0, 8'h00,1,0,0,1);
        drv("up1",      1,1,1,0, 8'h01,1,1,0,1);
        drv("up2",      1,1,2,0, 8'h02,1,1,0,1);
        drv("up_gap",   1,0,0,0, 8'h02,1,0,0,1);
        drv("up3",      1,1,3,0, 8'h03,1,1,0,1);
        drv("up4",      1,1,0,0, 8'h04,1,1,0,1);

        // Down wrap below zero
        drv("rst2",     0,0,0,0, 8'h00,1,0,0,0);
        drv("dn_lock",  1,1,0,0, 8'h00,1,0,0,1);
        drv("dn1",      1,1,3,0, 8'hFF,0,1,0,1);
        drv("dn2",      1,1,2,0, 8'hFE,0,1,0,1);

        // Three illegal jumps into FAULT, position retained
        drv("rst3",     0,0,0,0, 8'h00,1,0,0,0);
        drv("f_lock",   1,1,1,0, 8'h00,1,0,0,1);
        drv("f_up",     1,1,2,0, 8'h01,1,1,0,1);
        drv("f_err1",   1,1,0,0, 8'h01,1,0,1,1);
        drv("f_err2",   1,1,2,0, 8'h01,1,0,1,1);
        drv("f_err3",   1,1,0,0, 8'h01,1,0,1,2);
        drv("f_ignore", 1,1,1,0, 8'h01,1,0,0,2);
        drv("f_clrsmp", 1,1,3,1, 8'h01,1,0,0,0);
        drv("f_relock", 1,1,3,0, 8'h01,1,0,0,1);
        drv("f_step",   1,1,0,0, 8'h02,1,1,0,1);
        drv("clr_trk",  1,0,0,1, 8'h02,1,0,0,1);

        // Error counter cleared by holds and steps
        drv("e_err",    1,1,2,0, 8'h02,1,0,1,1);
        drv("e_hold",   1,1,2,0, 8'h02,1,0,0,1);
        drv("e_up",     1,1,3,0, 8'h03,1,1,0,1);
        drv("e_err1",   1,1,1,0, 8'h03,1,0,1,1);
        drv("e_err2",   1,1,3,0, 8'h03,1,0,1,1);
        drv("e_hold2",  1,1,3,0, 8'h03,1,0,0,1);
        drv("e_err3",   1,1,1,0, 8'h03,1,0,1,1);

        // Top-of-range wrap upward
        drv("rst4",     0,0,0,0, 8'h00,1,0,0,0);
        drv("t_lock",   1,1,0,0, 8'h00,1,0,0,1);
        drv("t_dn1",    1,1,3,0, 8'hFF,0,1,0,1);
        drv("t_dn2",    1,1,2,0, 8'hFE,0,1,0,1);
        drv("t_up1",    1,1,3,0, 8'hFF,1,1,0,1);
        drv("t_up2",    1,1,0,0, 8'h00,1,1,0,1);

        // Mid-sequence reset beats a concurrent sample
        drv("m_up1",    1,1,1,0, 8'h01,1,1,0,1);
        drv("m_up2",    1,1,2,0, 8'h02,1,1,0,1);
        drv("m_up3",    1,1,3,0, 8'h03,1,1,0,1);
        drv("m_up4",    1,1,0,0, 8'h04,1,1,0,1);
        drv("m_up5",    1,1,1,0, 8'h05,1,1,0,1);
        drv("m_gap",    1,0,2,0, 8'h05,1,0,0,1);
        drv("m_dn",     1,1,0,0, 8'h04,0,1,0,1);
        drv("m_rst",    0,1,2,1, 8'h00,1,0,0,0);
        drv("m_idle",   1,0,0,0, 8'h00,1,0,0,0);

        @(negedge clock);
        bus.sample_valid = 1'b0;
        bus.clear_fault  = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
